// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: occupancy states,
// control-bus bit positions and default bus widths.
package pipe_pkg;

  // Occupancy of a stage: nothing held, head only, or head plus skid entry.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  // Default widths used when a stage is instantiated without overrides.
  localparam int PIPE_DATA_W = 128;
  localparam int PIPE_CTRL_W = 16;
  localparam int PIPE_CNT_W  = 16;

  // Bit positions inside the control bus. Because the whole bus is zeroed
  // for a bubble, none of these can assert without a valid instruction.
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMWRITE = 1;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_BRANCH   = 3;
  localparam int CTRL_JUMP     = 4;
  localparam int CTRL_JAL      = 5;
  localparam int CTRL_TWOSCOMP = 6;
  localparam int CTRL_MUX1     = 7;
  localparam int CTRL_MUX2     = 8;
  localparam int CTRL_MUX3     = 9;
  localparam int CTRL_ALU_LSB  = 10;
  localparam int CTRL_ALU_W    = 3;
  localparam int CTRL_ALU_MSB  = CTRL_ALU_LSB + CTRL_ALU_W - 1;

endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// Saturating up-counter: counts INC pulses and sticks at all-ones.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = PIPE_CNT_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             INC,
  output logic [CNT_W-1:0] COUNT
);

  localparam logic [CNT_W-1:0] CNT_STEP = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_reg;

  // Count up on INC until the maximum value is reached, then hold.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      count_reg <= '0;
    end else if (INC && (count_reg != '1)) begin
      count_reg <= count_reg + CNT_STEP;
    end
  end

  assign COUNT = count_reg;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake, global stall, flush to
// bubble and an optional second (skid) entry. The control bus is masked to
// zero whenever the stage holds nothing, so bubbles never cause side effects.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              BUSYWAIT,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic [CTRL_W-1:0] IN_CTRL,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [CTRL_W-1:0] OUT_CTRL,
  output logic [CNT_W-1:0]  STALL_CNT
);

  pipe_state_t       state_reg;
  logic              out_valid_reg;
  logic [DATA_W-1:0] head_data_reg;
  logic [CTRL_W-1:0] head_ctrl_reg;
  logic              in_ready_int;

  logic in_fire;
  logic out_fire;
  logic stall_inc;

  // A stall freezes both sides and a flush overrides any transfer.
  assign in_fire   = IN_VALID & in_ready_int & ~BUSYWAIT & ~FLUSH;
  assign out_fire  = out_valid_reg & OUT_READY & ~BUSYWAIT & ~FLUSH;

  // A valid head that could not leave this cycle counts as a stalled cycle.
  assign stall_inc = out_valid_reg & (~OUT_READY | BUSYWAIT) & ~FLUSH;

  assign IN_READY  = in_ready_int;
  assign OUT_VALID = out_valid_reg;
  assign OUT_DATA  = head_data_reg;
  assign OUT_CTRL  = out_valid_reg ? head_ctrl_reg : '0;

  generate
    if (SKID != 0) begin : g_skid
      logic [DATA_W-1:0] skid_data_reg;
      logic [CTRL_W-1:0] skid_ctrl_reg;
      logic              in_ready_reg;

      // Ready comes straight from a flop so upstream never sees OUT_READY.
      assign in_ready_int = in_ready_reg;

      // Two-entry FIFO: the skid slot catches the entry that arrives while
      // the head is blocked, and is promoted once the head leaves.
      always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
          state_reg     <= EMPTY;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          head_data_reg <= '0;
          head_ctrl_reg <= '0;
          skid_data_reg <= '0;
          skid_ctrl_reg <= '0;
        end else if (FLUSH) begin
          state_reg     <= EMPTY;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
        end else begin
          case (state_reg)
            EMPTY: begin
              if (in_fire) begin
                head_data_reg <= IN_DATA;
                head_ctrl_reg <= IN_CTRL;
                state_reg     <= ONE;
                out_valid_reg <= 1'b1;
                in_ready_reg  <= 1'b1;
              end
            end
            ONE: begin
              if (in_fire && out_fire) begin
                head_data_reg <= IN_DATA;
                head_ctrl_reg <= IN_CTRL;
              end else if (in_fire) begin
                skid_data_reg <= IN_DATA;
                skid_ctrl_reg <= IN_CTRL;
                state_reg     <= TWO;
                in_ready_reg  <= 1'b0;
              end else if (out_fire) begin
                state_reg     <= EMPTY;
                out_valid_reg <= 1'b0;
              end
            end
            TWO: begin
              // Upstream sees ready low here, so only the head can move.
              if (out_fire) begin
                head_data_reg <= skid_data_reg;
                head_ctrl_reg <= skid_ctrl_reg;
                state_reg     <= ONE;
                in_ready_reg  <= 1'b1;
              end
            end
            default: begin
              state_reg     <= EMPTY;
              out_valid_reg <= 1'b0;
              in_ready_reg  <= 1'b1;
            end
          endcase
        end
      end
    end else begin : g_single
      // Single entry: accept whenever the head is free or leaving this cycle.
      assign in_ready_int = ~out_valid_reg | (OUT_READY & ~BUSYWAIT);

      // One-entry register; a simultaneous accept and release reloads it.
      always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
          state_reg     <= EMPTY;
          out_valid_reg <= 1'b0;
          head_data_reg <= '0;
          head_ctrl_reg <= '0;
        end else if (FLUSH) begin
          state_reg     <= EMPTY;
          out_valid_reg <= 1'b0;
        end else begin
          case (state_reg)
            EMPTY: begin
              if (in_fire) begin
                head_data_reg <= IN_DATA;
                head_ctrl_reg <= IN_CTRL;
                state_reg     <= ONE;
                out_valid_reg <= 1'b1;
              end
            end
            default: begin
              if (in_fire) begin
                head_data_reg <= IN_DATA;
                head_ctrl_reg <= IN_CTRL;
                state_reg     <= ONE;
                out_valid_reg <= 1'b1;
              end else if (out_fire) begin
                state_reg     <= EMPTY;
                out_valid_reg <= 1'b0;
              end
            end
          endcase
        end
      end
    end
  endgenerate

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .CLK  (CLK),
    .RESET(RESET),
    .INC  (stall_inc),
    .COUNT(STALL_CNT)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: one skid-buffered instance (4-bit counter) and one
// single-entry instance share the same stimulus; each is compared every cycle
// against a queue-based model of the stage, plus directed literal checks.
module tb_pipe_stage_buf;

  localparam int DW = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          busywait, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;

  logic          rdy1, v1, rdy0, v0;
  logic [DW-1:0] d1, d0;
  logic [CW-1:0] c1, c0;
  logic [3:0]    cnt1;
  logic [15:0]   cnt0;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) dut_skid (
    .CLK(clk), .RESET(rst_n), .BUSYWAIT(busywait), .FLUSH(flush),
    .IN_VALID(in_valid), .IN_READY(rdy1), .IN_DATA(in_data), .IN_CTRL(in_ctrl),
    .OUT_VALID(v1), .OUT_READY(out_ready), .OUT_DATA(d1), .OUT_CTRL(c1),
    .STALL_CNT(cnt1)
  );

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) dut_single (
    .CLK(clk), .RESET(rst_n), .BUSYWAIT(busywait), .FLUSH(flush),
    .IN_VALID(in_valid), .IN_READY(rdy0), .IN_DATA(in_data), .IN_CTRL(in_ctrl),
    .OUT_VALID(v0), .OUT_READY(out_ready), .OUT_DATA(d0), .OUT_CTRL(c0),
    .STALL_CNT(cnt0)
  );

  // Model: index 1 = skid instance (capacity 2), index 0 = single (capacity 1).
  logic [DW-1:0] mq_d [2][2];
  logic [CW-1:0] mq_c [2][2];
  int            mn   [2];
  logic [DW-1:0] mlast[2];
  int            mcnt [2];
  int            mmax [2] = '{65535, 15};
  bit            m_vf, m_in, m_out;

  function automatic bit m_valid(int k);
    return mn[k] > 0;
  endfunction

  function automatic bit m_ready(int k);
    if (k == 1) return mn[1] < 2;
    return (mn[0] == 0) || (out_ready && !busywait);
  endfunction

  function automatic logic [DW-1:0] m_data(int k);
    return (mn[k] > 0) ? mq_d[k][0] : mlast[k];
  endfunction

  function automatic logic [CW-1:0] m_ctrl(int k);
    return (mn[k] > 0) ? mq_c[k][0] : '0;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state advance from the inputs present at the rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        mn[k] = 0;
        mlast[k] = '0;
        mcnt[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_vf  = m_valid(k);
        m_in  = in_valid && m_ready(k) && !busywait && !flush;
        m_out = m_vf && out_ready && !busywait && !flush;
        if (m_vf && (!out_ready || busywait) && !flush && mcnt[k] < mmax[k])
          mcnt[k]++;
        if (flush) begin
          mn[k] = 0;
        end else begin
          if (m_out) begin
            mq_d[k][0] = mq_d[k][1];
            mq_c[k][0] = mq_c[k][1];
            mn[k]--;
          end
          if (m_in) begin
            mq_d[k][mn[k]] = in_data;
            mq_c[k][mn[k]] = in_ctrl;
            mn[k]++;
          end
        end
        if (mn[k] > 0) mlast[k] = mq_d[k][0];
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("skid_valid", v1,   m_valid(1));
      chk("skid_ready", rdy1, m_ready(1));
      chk("skid_data",  d1,   m_data(1));
      chk("skid_ctrl",  c1,   m_ctrl(1));
      chk("skid_cnt",   cnt1, mcnt[1]);
      chk("single_valid", v0,   m_valid(0));
      chk("single_ready", rdy0, m_ready(0));
      chk("single_data",  d0,   m_data(0));
      chk("single_ctrl",  c0,   m_ctrl(0));
      chk("single_cnt",   cnt0, mcnt[0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, logic [DW-1:0] d, logic [CW-1:0] c, bit ordy);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
  endtask

  initial begin
    busywait = 0; flush = 0;
    drive(0, '0, '0, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;

    // Idle after reset
    @(negedge clk);
    chk("rst_valid", v1, 0);
    chk("rst_ready_skid", rdy1, 1);
    chk("rst_ready_single", rdy0, 1);
    chk("rst_cnt", cnt1, 0);
    chk("rst_data", d1, 0);
    chk("rst_ctrl", c1, 0);
    tick();

    // Streaming 1..8 with OUT_READY high: one cycle late, no gaps
    for (int i = 1; i <= 9; i++) begin
      drive(i <= 8, DW'(i), CW'(16'h0100 + i), 1);
      @(negedge clk);
      if (i > 1) begin
        chk("stream_skid_data", d1, i - 1);
        chk("stream_single_data", d0, i - 1);
        chk("stream_skid_valid", v1, 1);
        chk("stream_single_valid", v0, 1);
      end
      tick();
    end

    // Backpressure on the skid instance: A, B fill it, C waits upstream
    drive(1, 32'hA, 16'h000A, 0); tick();
    drive(1, 32'hB, 16'h000B, 0); tick();
    drive(1, 32'hC, 16'h000C, 0);
    @(negedge clk);
    chk("bp_ready_low", rdy1, 0);
    chk("bp_head_a", d1, 32'hA);
    tick();
    tick();
    out_ready = 1;
    @(negedge clk);
    chk("bp_stall_cnt", cnt1, 3);
    chk("bp_out_a", d1, 32'hA);
    tick();
    @(negedge clk);
    chk("bp_out_b", d1, 32'hB);
    chk("bp_ready_back", rdy1, 1);
    tick();
    in_valid = 0;
    @(negedge clk);
    chk("bp_out_c", d1, 32'hC);
    tick();
    @(negedge clk);
    chk("bp_drained", v1, 0);

    // Flush while full: incoming entry is dropped, stage becomes a bubble
    drive(1, 32'hD, 16'h000D, 0); tick();
    drive(1, 32'hE, 16'h000E, 0); tick();
    drive(1, 32'hF, 16'h000F, 1);
    flush = 1;
    @(negedge clk);
    chk("fl_full", rdy1, 0);
    tick();
    flush = 0;
    in_valid = 0;
    @(negedge clk);
    chk("fl_valid", v1, 0);
    chk("fl_ctrl", c1, 0);
    chk("fl_cnt", cnt1, 4);
    tick();

    // BUSYWAIT freezes entry X with CTRL 00FF for three edges
    drive(1, 32'h55, 16'h00FF, 1); tick();
    busywait = 1;
    drive(1, 32'h66, 16'h1234, 1);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("bw_data", d1, 32'h55);
      chk("bw_ctrl", c1, 16'h00FF);
      tick();
    end
    busywait = 0;
    in_valid = 0;
    @(negedge clk);
    chk("bw_data_after", d1, 32'h55);
    chk("bw_cnt", cnt1, 7);
    tick();
    @(negedge clk);
    chk("bw_no_accept", v1, 0);

    // Saturation of the 4-bit counter
    drive(1, 32'h77, 16'h0077, 0); tick();
    in_valid = 0;
    repeat (20) tick();
    @(negedge clk);
    chk("sat_cnt", cnt1, 15);
    tick();
    @(negedge clk);
    chk("sat_hold", cnt1, 15);
    chk("sat_head", d1, 32'h77);
    out_ready = 1;
    tick();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      in_ctrl   = CW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      busywait  = ($urandom_range(0, 4) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      tick();
    end

    // Asynchronous reset while the skid instance is full
    busywait = 0; flush = 0;
    drive(1, 32'h88, 16'h0088, 0); tick();
    drive(1, 32'h99, 16'h0099, 0); tick();
    in_valid = 0;
    @(negedge clk);
    chk("ar_full", rdy1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", v1, 0);
    chk("ar_ctrl", c1, 0);
    chk("ar_cnt", cnt1, 0);
    chk("ar_data", d1, 0);
    chk("ar_single_valid", v0, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("ar_ready_after", rdy1, 1);
    chk("ar_valid_after", v1, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline-stage register with valid/ready handshake, global stall, flush-to-bubble and an optional two-entry skid buffer. It is the successor to the fixed-field stage registers between IF/ID/EX/MEM/WB. Each stage instance carries a generic payload bus (DATA) plus a control bus (CTRL). CTRL is forced to zero whenever the stage holds no valid instruction, so a bubble can never write registers or memory. A saturating stall counter per stage supports pipeline performance debug.

## Interface
Parameters:
- DATA_W, 128: payload width (PC, PC+4, IMM, operands, FUNC3, RD, packed by the instantiating stage)
- CTRL_W, 16: control width (ALU op, mux selects, REGWRITE, MEMWRITE, MEMREAD, BRANCH, JUMP, JAL, TWOSCOMP)
- SKID, 1: 1 gives a 2-entry skid buffer with registered IN_READY; 0 gives a single entry with combinational IN_READY
- CNT_W, 16: stall counter width

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  reset, asynchronous, active-low
- BUSYWAIT  in  1  global memory stall; freezes the stage
- FLUSH  in  1  discard all held entries (branch/jump redirect)
- IN_VALID  in  1  upstream has an entry
- IN_READY  out  1  stage can accept an entry
- IN_DATA  in  DATA_W  upstream payload
- IN_CTRL  in  CTRL_W  upstream control
- OUT_VALID  out  1  head entry valid
- OUT_READY  in  1  downstream accepts head
- OUT_DATA  out  DATA_W  head payload
- OUT_CTRL  out  CTRL_W  head control; all-zero when OUT_VALID=0
- STALL_CNT  out  CNT_W  saturating count of stalled valid cycles

## Operation
Handshake qualifiers:
- in_fire = IN_VALID & IN_READY & ~BUSYWAIT & ~FLUSH
- out_fire = OUT_VALID & OUT_READY & ~BUSYWAIT & ~FLUSH

States (SKID=1):
- EMPTY (0 entries): IN_READY=1, OUT_VALID=0
- ONE (1 entry): IN_READY=1, OUT_VALID=1
- TWO (2 entries, head+skid): IN_READY=0, OUT_VALID=1

Transitions (SKID=1):
- EMPTY: in_fire → ONE.
- ONE: in_fire & ~out_fire → TWO. out_fire & ~in_fire → EMPTY. Both fire → ONE, and the head is replaced by the new entry.
- TWO: out_fire → ONE; the skid entry becomes head. in_fire cannot occur in TWO.
- Order is strictly FIFO. The skid entry is never visible before the head.

SKID=0:
- States are EMPTY and ONE only.
- IN_READY = ~OUT_VALID | (OUT_READY & ~BUSYWAIT).
- In ONE, simultaneous in_fire and out_fire stays in ONE and loads the new entry.

Flush, stall and output rules:
- FLUSH=1 at a rising edge: next state EMPTY, regardless of IN_VALID, OUT_READY or BUSYWAIT. FLUSH dominates BUSYWAIT.
- BUSYWAIT=1 (without FLUSH): state and all entries hold. No transfer is counted on either side. IN_READY and OUT_VALID still reflect state.
- OUT_CTRL = head ctrl when OUT_VALID=1, else 0.
- OUT_DATA holds its last head value when invalid; it is 0 after reset.

STALL_CNT:
- Increments by 1 each edge where OUT_VALID=1 and (OUT_READY=0 or BUSYWAIT=1) and FLUSH=0.
- Saturates at 2^CNT_W−1.
- Cleared only by reset.

## Timing
- Reset (RESET=0, asynchronous): state EMPTY, OUT_VALID=0, OUT_DATA=0, OUT_CTRL=0, STALL_CNT=0, skid entry=0. IN_READY=1 for SKID=1; IN_READY=1 for SKID=0 (empty). Deassertion is sampled at the next rising edge.
- Latency: 1 cycle. An entry accepted at edge N is presented on OUT_* after edge N.
- Throughput: 1 entry/cycle when OUT_READY is held high, for both SKID values.
- SKID=1: IN_READY is a pure register output with no combinational path from OUT_READY. SKID=0 has a combinational OUT_READY→IN_READY path.
- No intra-assignment delays. All state updates use non-blocking assignment on the rising edge of CLK or the falling edge of RESET.
- Reset mid-transfer: held entries are lost and no partial output appears.

## Structure
- Shared package pipe_pkg holds:
  - the state enum (EMPTY, ONE, TWO);
  - CTRL bit-index constants (REGWRITE, MEMWRITE, MEMREAD, BRANCH, JUMP, JAL, TWOSCOMP, MUX1..3, ALU field);
  - the default widths.
- One sub-module: sat_counter (parameter CNT_W; ports CLK, RESET, INC, COUNT), instantiated for STALL_CNT.
- Head and skid registers plus the state machine live in pipe_stage_buf. The SKID=0 variant is selected by a generate block.

## Test plan
- Reset/idle: RESET low mid-cycle with the stage in TWO → OUT_VALID=0, OUT_CTRL=0, STALL_CNT=0 immediately. After release, IN_READY=1.
- Streaming: IN_VALID=1 with DATA 1..8 and OUT_READY=1 → OUT_DATA 1..8 on consecutive cycles, one cycle late, no gaps (both SKID values).
- Backpressure: SKID=1, send A,B,C with OUT_READY=0 → state TWO after B, IN_READY=0, C held upstream. Raise OUT_READY → A, B, C delivered in order. STALL_CNT equals the number of stalled valid cycles.
- Flush: stage in TWO, FLUSH=1 with IN_VALID=1 and OUT_READY=1 → next cycle OUT_VALID=0, OUT_CTRL=0, and the input entry is dropped.
- BUSYWAIT: hold BUSYWAIT=1 for 3 cycles with entry X and CTRL=16'h00FF → OUT_DATA=X and OUT_CTRL=16'h00FF held, no acceptance, STALL_CNT +3.
- Saturation: CNT_W=4, stall for 20 cycles → STALL_CNT=15 and stays at 15.
